multi_cycle_controller: RTL and testbench
=========================================

MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 clk  input  1  sole clock; all state updates on the rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 opcode  input  6  instruction[31:26] from the datapath instruction register.
REQ-004 func  input  6  instruction[5:0] from the datapath instruction register.
REQ-005 mem_ready  input  1  memory access complete; present only with MC_MEM_HANDSHAKE_EN.
REQ-006 PC_Write  output  1  unconditional PC load.
REQ-007 PC_Write_Cond  output  1  PC load qualified by datapath Zero (beq).
REQ-008 IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 Mem_Read  output  1  memory read strobe.
REQ-010 Mem_Write  output  1  memory write strobe.
REQ-011 IR_Write  output  1  instruction register load.
REQ-012 Reg_Write  output  1  register file write enable.
REQ-013 ALUsrcA  output  1  ALU A operand: 0 = PC, 1 = register A.
REQ-014 ALUsrcB  output  2  ALU B operand: 00 = register B, 01 = 4, 10 = sign-extend, 11 = sign-extend<<2.
REQ-015 PCSrc  output  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], instr[25:0], 2'b00}, 11 = register A.
REQ-016 regDst  output  2  write register: 00 = rt, 01 = rd, 10 = 31.
REQ-017 writeDst  output  2  write data: 00 = memory data register, 01 = ALUOut, 10 = PC.
REQ-018 ALUOperation  output  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
REQ-019 illegal_op  output  1  one-cycle pulse in DECODE for an unsupported opcode or R-type func.

Function
REQ-020 The block SHALL be a Moore FSM. Outputs are a function of state only, except in the handshake states of REQ-034. Any output not listed for a state is 0.
REQ-021 FETCH SHALL drive Mem_Read=1, IorD=0, IR_Write=1, ALUsrcA=0, ALUsrcB=01, ALUOperation=ADD, PCSrc=00, PC_Write=1, then go to DECODE.
REQ-022 DECODE SHALL drive ALUsrcA=0, ALUsrcB=11, ALUOperation=ADD, then branch by opcode.
- lw 100011 / sw 101011 -> MEM_ADR
- R-type 000000 -> R_EXEC, or -> JR if func=001000
- addi 001000 / slti 001010 -> I_EXEC
- beq 000100 -> BRANCH
- j 000010 -> JUMP
- jal 000011 -> JAL
- anything else -> FETCH with illegal_op=1
REQ-023 R-type funcs SHALL be add 100000, sub 100010, and 100100, or 100101, slt 101010 and jr 001000. Any other func SHALL be illegal.
REQ-024 MEM_ADR SHALL drive ALUsrcA=1, ALUsrcB=10, ADD, then go to MEM_RD (lw) or MEM_WR (sw).
REQ-025 MEM_RD SHALL drive Mem_Read=1, IorD=1, then go to MEM_WB. MEM_WB SHALL drive Reg_Write=1, regDst=00, writeDst=00, then go to FETCH.
REQ-026 MEM_WR SHALL drive Mem_Write=1, IorD=1, then go to FETCH.
REQ-027 R_EXEC SHALL drive ALUsrcA=1, ALUsrcB=00, with ALUOperation decoded from func. R_WB SHALL drive Reg_Write=1, regDst=01, writeDst=01.
REQ-028 I_EXEC SHALL drive ALUsrcA=1, ALUsrcB=10, ADD (addi) or SLT (slti). I_WB SHALL drive Reg_Write=1, regDst=00, writeDst=01.
REQ-029 BRANCH SHALL drive ALUsrcA=1, ALUsrcB=00, SUB, PC_Write_Cond=1, PCSrc=01.
REQ-030 JUMP SHALL drive PC_Write=1, PCSrc=10. JAL SHALL additionally drive Reg_Write=1, regDst=10, writeDst=10. JR SHALL drive PC_Write=1, PCSrc=11.
REQ-031 BRANCH, JUMP, JAL and JR SHALL return to FETCH, giving these latencies: lw 5, sw/R/addi/slti 4, beq/j/jal/jr 3, illegal 2 cycles.

Reset
REQ-032 While reset=1, every output SHALL be 0 and the state SHALL be FETCH, taking effect immediately and regardless of clk, including mid-instruction.
REQ-033 The first rising edge after reset deassertion SHALL execute FETCH.

Configuration
REQ-034 With MC_MEM_HANDSHAKE_EN defined, FETCH, MEM_RD and MEM_WR SHALL hold until mem_ready=1. Mem_Read or Mem_Write stays asserted throughout. PC_Write and IR_Write assert only in the mem_ready=1 cycle. Without the macro, mem_ready SHALL be absent and those states SHALL last one cycle.

Structure
REQ-035 Package mc_ctrl_pkg SHALL hold the state enum, opcode and func constants, and ALUOperation codes.
REQ-036 Sub-module mc_alu_dec SHALL map the state class and func to ALUOperation combinationally.

Verification
REQ-037 Reset pulse mid-MEM_RD -> all outputs 0 immediately. After release: FETCH outputs, with PC_Write=1 and IR_Write=1.
REQ-038 opcode=100011 -> state sequence FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB. Reg_Write=1 only in cycle 5, with regDst=00.
REQ-039 opcode=000000, func=101010 -> ALUOperation=0111 in cycle 3. Reg_Write=1, regDst=01, writeDst=01 in cycle 4.
REQ-040 opcode=000011 -> cycle 3: PC_Write=1, PCSrc=10, Reg_Write=1, regDst=10, writeDst=10. func=001000 R-type -> cycle 3: PCSrc=11.
REQ-041 opcode=111111 -> illegal_op=1 in DECODE, then FETCH next cycle, with no Reg_Write or Mem_Write.
REQ-042 With MC_MEM_HANDSHAKE_EN, mem_ready low for 3 cycles during sw MEM_WR -> Mem_Write=1 for 4 cycles, then FETCH.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS-style controller.
// States, opcode/func encodings, ALU codes and the control word bundle.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_R_EXEC,
    S_R_WB,
    S_I_EXEC,
    S_I_WB,
    S_BRANCH,
    S_JUMP,
    S_JAL,
    S_JR
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_JR  = 6'b001000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [2:0] {
    AC_NONE,
    AC_ADD,
    AC_SUB,
    AC_SLT,
    AC_FUNC
  } alu_class_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] reg_dst;
    logic [1:0] write_dst;
    logic       illegal;
  } ctrl_t;

  // R-type funcs that go through the ALU (jr is handled separately)
  function automatic logic func_is_alu(input logic [5:0] f);
    return f inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation decoder: maps the state's ALU class and the R-type
// func field to a 4-bit ALUOperation code.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  alu_class_t  cls,
  input  logic [5:0]  func,
  output logic [3:0]  alu_op
);

  always_comb begin
    alu_op = ALU_AND;
    unique case (cls)
      AC_NONE: alu_op = ALU_AND;
      AC_ADD:  alu_op = ALU_ADD;
      AC_SUB:  alu_op = ALU_SUB;
      AC_SLT:  alu_op = ALU_SLT;
      AC_FUNC: begin
        case (func)
          F_ADD:   alu_op = ALU_ADD;
          F_SUB:   alu_op = ALU_SUB;
          F_AND:   alu_op = ALU_AND;
          F_OR:    alu_op = ALU_OR;
          F_SLT:   alu_op = ALU_SLT;
          default: alu_op = ALU_AND;
        endcase
      end
      default: alu_op = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Moore FSM controller for a multi-cycle MIPS subset datapath.
// MC_MEM_HANDSHAKE_EN adds mem_ready stalls in FETCH, MEM_RD, MEM_WR.
module multi_cycle_controller
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
`ifdef MC_MEM_HANDSHAKE_EN
  input  logic       mem_ready,
`endif
  output logic       PC_Write,
  output logic       PC_Write_Cond,
  output logic       IorD,
  output logic       Mem_Read,
  output logic       Mem_Write,
  output logic       IR_Write,
  output logic       Reg_Write,
  output logic       ALUsrcA,
  output logic [1:0] ALUsrcB,
  output logic [1:0] PCSrc,
  output logic [1:0] regDst,
  output logic [1:0] writeDst,
  output logic [3:0] ALUOperation,
  output logic       illegal_op
);

  state_t     state, next;
  ctrl_t      c, q;
  alu_class_t cls;
  logic [3:0] alu_op;
  logic       mem_done;

`ifdef MC_MEM_HANDSHAKE_EN
  assign mem_done = mem_ready;
`else
  assign mem_done = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next;
  end

  always_comb begin
    c    = '0;
    cls  = AC_NONE;
    next = state;
    unique case (state)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        cls         = AC_ADD;
        if (mem_done) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
          next       = S_DECODE;
        end
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        cls         = AC_ADD;
        case (opcode)
          OP_LW, OP_SW:     next = S_MEM_ADR;
          OP_ADDI, OP_SLTI: next = S_I_EXEC;
          OP_BEQ:           next = S_BRANCH;
          OP_J:             next = S_JUMP;
          OP_JAL:           next = S_JAL;
          OP_RTYPE: begin
            if (func == F_JR)          next = S_JR;
            else if (func_is_alu(func)) next = S_R_EXEC;
            else begin
              c.illegal = 1'b1;
              next      = S_FETCH;
            end
          end
          default: begin
            c.illegal = 1'b1;
            next      = S_FETCH;
          end
        endcase
      end
      S_MEM_ADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        cls         = AC_ADD;
        next        = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
        if (mem_done) next = S_MEM_WB;
      end
      S_MEM_WB: begin
        c.reg_write = 1'b1;
        next        = S_FETCH;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
        if (mem_done) next = S_FETCH;
      end
      S_R_EXEC: begin
        c.alu_src_a = 1'b1;
        cls         = AC_FUNC;
        next        = S_R_WB;
      end
      S_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 2'b01;
        c.write_dst = 2'b01;
        next        = S_FETCH;
      end
      S_I_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        cls         = (opcode == OP_SLTI) ? AC_SLT : AC_ADD;
        next        = S_I_WB;
      end
      S_I_WB: begin
        c.reg_write = 1'b1;
        c.write_dst = 2'b01;
        next        = S_FETCH;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.pc_write_cond = 1'b1;
        c.pc_src        = 2'b01;
        cls             = AC_SUB;
        next            = S_FETCH;
      end
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = 2'b10;
        next       = S_FETCH;
      end
      S_JAL: begin
        c.pc_write  = 1'b1;
        c.pc_src    = 2'b10;
        c.reg_write = 1'b1;
        c.reg_dst   = 2'b10;
        c.write_dst = 2'b10;
        next        = S_FETCH;
      end
      S_JR: begin
        c.pc_write = 1'b1;
        c.pc_src   = 2'b11;
        next       = S_FETCH;
      end
      default: next = S_FETCH;
    endcase
  end

  mc_alu_dec u_alu_dec (
    .cls    (cls),
    .func   (func),
    .alu_op (alu_op)
  );

  // Reset forces every output low even though the state sits in FETCH
  assign q = reset ? '0 : c;

  assign PC_Write      = q.pc_write;
  assign PC_Write_Cond = q.pc_write_cond;
  assign IorD          = q.iord;
  assign Mem_Read      = q.mem_read;
  assign Mem_Write     = q.mem_write;
  assign IR_Write      = q.ir_write;
  assign Reg_Write     = q.reg_write;
  assign ALUsrcA       = q.alu_src_a;
  assign ALUsrcB       = q.alu_src_b;
  assign PCSrc         = q.pc_src;
  assign regDst        = q.reg_dst;
  assign writeDst      = q.write_dst;
  assign illegal_op    = q.illegal;
  assign ALUOperation  = reset ? 4'b0000 : alu_op;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench for multi_cycle_controller: vector table,
// hand sequences and a random run against a step-list reference model.
module tb_multi_cycle_controller;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] pcs;
    logic [1:0] rdst;
    logic [1:0] wdst;
    logic [3:0] aop;
    logic       ill;
  } cw_t;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    int          lat;
    int          cyc;
    logic        rw;
    logic [1:0]  rdst;
    logic [1:0]  wdst;
    logic [1:0]  pcs;
    logic [3:0]  aop;
    logic        ill;
    logic        mw;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] func = '0;
`ifdef MC_MEM_HANDSHAKE_EN
  logic       mem_ready = 1'b1;
`endif
  logic       PC_Write, PC_Write_Cond, IorD, Mem_Read, Mem_Write;
  logic       IR_Write, Reg_Write, ALUsrcA, illegal_op;
  logic [1:0] ALUsrcB, PCSrc, regDst, writeDst;
  logic [3:0] ALUOperation;
  cw_t        dut_cw;

  int nchk = 0;
  int nerr = 0;

  multi_cycle_controller dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .func          (func),
`ifdef MC_MEM_HANDSHAKE_EN
    .mem_ready     (mem_ready),
`endif
    .PC_Write      (PC_Write),
    .PC_Write_Cond (PC_Write_Cond),
    .IorD          (IorD),
    .Mem_Read      (Mem_Read),
    .Mem_Write     (Mem_Write),
    .IR_Write      (IR_Write),
    .Reg_Write     (Reg_Write),
    .ALUsrcA       (ALUsrcA),
    .ALUsrcB       (ALUsrcB),
    .PCSrc         (PCSrc),
    .regDst        (regDst),
    .writeDst      (writeDst),
    .ALUOperation  (ALUOperation),
    .illegal_op    (illegal_op)
  );

  always #5 clk = ~clk;

  assign dut_cw = {PC_Write, PC_Write_Cond, IorD, Mem_Read, Mem_Write,
                   IR_Write, Reg_Write, ALUsrcA, ALUsrcB, PCSrc,
                   regDst, writeDst, ALUOperation, illegal_op};

  function automatic logic fn_legal(input logic [5:0] fn);
    return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
           fn == 6'h25 || fn == 6'h2a;
  endfunction

  // Sequence of named steps an instruction walks through
  function automatic string steps(input logic [5:0] op,
                                  input logic [5:0] fn);
    case (op)
      6'h23: return "FDARW";
      6'h2b: return "FDAS";
      6'h08, 6'h0a: return "FDIJ";
      6'h04: return "FDB";
      6'h02: return "FDP";
      6'h03: return "FDL";
      6'h00: begin
        if (fn == 6'h08) return "FDK";
        if (fn_legal(fn)) return "FDXY";
        return "FD";
      end
      default: return "FD";
    endcase
  endfunction

  function automatic logic [3:0] r_aop(input logic [5:0] fn);
    case (fn)
      6'h20: return 4'b0010;
      6'h22: return 4'b0110;
      6'h25: return 4'b0001;
      6'h2a: return 4'b0111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic cw_t step_out(input byte s, input logic [5:0] op,
                                   input logic [5:0] fn);
    cw_t w = '0;
    case (s)
      "F": begin w.mr = 1; w.irw = 1; w.pcw = 1; w.asb = 1; w.aop = 2; end
      "D": begin
        w.asb = 3; w.aop = 2;
        w.ill = (steps(op, fn).len() == 2);
      end
      "A": begin w.asa = 1; w.asb = 2; w.aop = 2; end
      "R": begin w.mr = 1; w.iord = 1; end
      "W": w.rw = 1;
      "S": begin w.mw = 1; w.iord = 1; end
      "X": begin w.asa = 1; w.aop = r_aop(fn); end
      "Y": begin w.rw = 1; w.rdst = 1; w.wdst = 1; end
      "I": begin
        w.asa = 1; w.asb = 2;
        w.aop = (op == 6'h0a) ? 4'b0111 : 4'b0010;
      end
      "J": begin w.rw = 1; w.wdst = 1; end
      "B": begin w.asa = 1; w.aop = 6; w.pcwc = 1; w.pcs = 1; end
      "P": begin w.pcw = 1; w.pcs = 2; end
      "L": begin w.pcw = 1; w.pcs = 2; w.rw = 1; w.rdst = 2; w.wdst = 2; end
      "K": begin w.pcw = 1; w.pcs = 3; end
      default: w = '0;
    endcase
    return w;
  endfunction

  task automatic chk(input string name, input cw_t got, input cw_t exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Enters in FETCH, leaves in FETCH of the following instruction
  task automatic run_model(input logic [5:0] op, input logic [5:0] fn);
    string s;
    s = steps(op, fn);
    opcode = op;
    func = fn;
    #1;
    for (int k = 0; k < s.len(); k++) begin
      chk($sformatf("model op=%h fn=%h step=%0d", op, fn, k),
          dut_cw, step_out(s[k], op, fn));
      tick();
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int c;
    logic [12:0] got, exp;
    opcode = v.op;
    func = v.fn;
    #1;
    c = 1;
    while (1) begin
      if (c == v.cyc) begin
        got = {Reg_Write, regDst, writeDst, PCSrc, ALUOperation,
               illegal_op, Mem_Write};
        exp = {v.rw, v.rdst, v.wdst, v.pcs, v.aop, v.ill, v.mw};
        nchk++;
        if (got !== exp) begin
          nerr++;
          $display("FAIL vec%0d fields got=%h exp=%h", idx, got, exp);
        end
      end
      tick();
      if (IR_Write || c >= 12) break;
      c++;
    end
    chk_int($sformatf("vec%0d latency", idx), c, v.lat);
  endtask

  vec_t vt[$];
  logic [5:0] ops[8] = '{6'h23, 6'h2b, 6'h00, 6'h08,
                         6'h0a, 6'h04, 6'h02, 6'h03};
  logic [5:0] fns[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h08};

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // op fn lat cyc rw rdst wdst pcs aop ill mw
    vt.push_back('{6'h23, 6'h00, 5, 5, 1, 0, 0, 0, 4'h0, 0, 0});
    vt.push_back('{6'h23, 6'h00, 5, 2, 0, 0, 0, 0, 4'h2, 0, 0});
    vt.push_back('{6'h2b, 6'h00, 4, 4, 0, 0, 0, 0, 4'h0, 0, 1});
    vt.push_back('{6'h00, 6'h2a, 4, 3, 0, 0, 0, 0, 4'h7, 0, 0});
    vt.push_back('{6'h00, 6'h2a, 4, 4, 1, 1, 1, 0, 4'h0, 0, 0});
    vt.push_back('{6'h00, 6'h20, 4, 3, 0, 0, 0, 0, 4'h2, 0, 0});
    vt.push_back('{6'h00, 6'h22, 4, 3, 0, 0, 0, 0, 4'h6, 0, 0});
    vt.push_back('{6'h00, 6'h24, 4, 3, 0, 0, 0, 0, 4'h0, 0, 0});
    vt.push_back('{6'h00, 6'h25, 4, 3, 0, 0, 0, 0, 4'h1, 0, 0});
    vt.push_back('{6'h03, 6'h00, 3, 3, 1, 2, 2, 2, 4'h0, 0, 0});
    vt.push_back('{6'h00, 6'h08, 3, 3, 0, 0, 0, 3, 4'h0, 0, 0});
    vt.push_back('{6'h3f, 6'h00, 2, 2, 0, 0, 0, 0, 4'h2, 1, 0});
    vt.push_back('{6'h00, 6'h3f, 2, 2, 0, 0, 0, 0, 4'h2, 1, 0});
    vt.push_back('{6'h04, 6'h00, 3, 3, 0, 0, 0, 1, 4'h6, 0, 0});
    vt.push_back('{6'h02, 6'h00, 3, 3, 0, 0, 0, 2, 4'h0, 0, 0});
    vt.push_back('{6'h08, 6'h00, 4, 3, 0, 0, 0, 0, 4'h2, 0, 0});
    vt.push_back('{6'h0a, 6'h00, 4, 3, 0, 0, 0, 0, 4'h7, 0, 0});
    vt.push_back('{6'h0a, 6'h00, 4, 4, 1, 0, 1, 0, 4'h0, 0, 0});

    tick();
    chk("reset outputs", dut_cw, '0);
    reset = 1'b0;
    #1;
    chk("first fetch", dut_cw, step_out("F", 6'h00, 6'h00));

    foreach (vt[i]) run_vec(i, vt[i]);

    // Reset pulse in the middle of a load's MEM_RD
    opcode = 6'h23;
    func = 6'h00;
    repeat (3) tick();
    chk("in MEM_RD", dut_cw, step_out("R", 6'h23, 6'h00));
    reset = 1'b1;
    #1;
    chk("async reset", dut_cw, '0);
    @(posedge clk);
    #1;
    chk("reset held", dut_cw, '0);
    tick();
    reset = 1'b0;
    #1;
    chk("fetch after reset", dut_cw, step_out("F", 6'h00, 6'h00));

    run_model(6'h23, 6'h00);
    run_model(6'h00, 6'h2a);
    run_model(6'h03, 6'h00);
    run_model(6'h00, 6'h08);
    run_model(6'h3f, 6'h00);

`ifdef MC_MEM_HANDSHAKE_EN
    begin
      int mw_cnt;
      mw_cnt = 0;
      opcode = 6'h2b;
      func = 6'h00;
      repeat (3) tick();
      mem_ready = 1'b0;
      repeat (3) begin
        if (Mem_Write) mw_cnt++;
        tick();
      end
      mem_ready = 1'b1;
      #1;
      if (Mem_Write) mw_cnt++;
      tick();
      chk_int("hs mem_write cycles", mw_cnt, 4);
      chk("hs back to fetch", dut_cw, step_out("F", 6'h00, 6'h00));
    end
`endif

    for (int n = 0; n < 150; n++) begin
      logic [5:0] op, fn;
      int r;
      r = $urandom_range(0, 9);
      op = (r < 8) ? ops[r] : 6'($urandom_range(0, 63));
      r = $urandom_range(0, 7);
      fn = (r < 6) ? fns[r] : 6'($urandom_range(0, 63));
      run_model(op, fn);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
